// File: rtl/uart_tft_pkg.sv
// ----------------------------------------------------------------------------
// uart_tft_pkg
// Shared definitions for the UART-to-TFT image path.
//   pk_state_t     : framer state (HUNT, HDR, DATA)
//   DEF_IMG_H/V    : default panel geometry (pixels per line, lines per frame)
//   DEF_SYNC_WORD  : default two-byte frame header, high byte sent first
//   clog2()        : ceiling log2, usable in parameter/localparam context
// ----------------------------------------------------------------------------
package uart_tft_pkg;

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } pk_state_t;

    localparam int          DEF_IMG_H     = 800;
    localparam int          DEF_IMG_V     = 480;
    localparam logic [15:0] DEF_SYNC_WORD = 16'hAA55;

    // Smallest n with 2**n >= value; clog2(1) = 0.
    function automatic int clog2(input int unsigned value);
        int res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/uart_pixel_packer_gap_timer.sv
// ----------------------------------------------------------------------------
// gap_timer
// Inter-byte idle timer. Down-counter reloaded to TIMEOUT_CYC-1 whenever it
// is not running, on every clear, and on expiry. expire is raised on the
// TIMEOUT_CYC-th consecutive running cycle without a clear; a clear in that
// same cycle wins and suppresses expiry.
// Ports:
//   clk     in   clock
//   rst_n   in   asynchronous active-low reset
//   run     in   count only while high (owner is inside a frame)
//   clr     in   restart the idle interval (a byte arrived)
//   expire  out  one-cycle expiry indication (combinational from the counter)
// ----------------------------------------------------------------------------
module gap_timer
    import uart_tft_pkg::*;
#(
    parameter int TIMEOUT_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    input  logic clr,
    output logic expire
);

    localparam int            CW     = (clog2(TIMEOUT_CYC) < 1) ? 1 : clog2(TIMEOUT_CYC);
    localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] remain;

    // Terminal count: remain == 0 means this is the last allowed idle cycle.
    assign expire = run && !clr && (remain == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain <= RELOAD;
        end else if (!run || clr || expire) begin
            remain <= RELOAD;
        end else begin
            remain <= remain - 1'b1;
        end
    end

endmodule

// File: rtl/uart_pixel_packer.sv
// ----------------------------------------------------------------------------
// uart_pixel_packer
// Packs UART bytes into PIX_W-bit pixels for the SDRAM write FIFO, optionally
// locking onto a two-byte frame header, counting pixels per frame and
// aborting stalled frames via an inter-byte timeout.
//
// state | meaning
// ------+------------------------------------------------------------------
// HUNT  | waiting for header high byte SYNC_WORD[15:8]
// HDR   | high byte seen, next byte must be SYNC_WORD[7:0]
// DATA  | in a frame: bytes are pixel data, idle timer running
//
// Ports:
//   clk          in   single clock (UART byte domain)
//   rst_n        in   asynchronous active-low reset
//   byte_data    in   [7:0] received byte
//   byte_valid   in   one-cycle qualifier for byte_data
//   pix_data     out  [PIX_W-1:0] last packed pixel
//   pix_valid    out  one-cycle FIFO write strobe
//   frame_load   out  one-cycle SDRAM write-address reload
//   frame_done   out  one-cycle strobe with the last pixel of a frame
//   pix_cnt      out  pixels emitted in the current frame (saturates at NPIX)
//   err_timeout  out  one-cycle strobe when a frame is aborted by timeout
//   locked       out  high while a frame is being received
// ----------------------------------------------------------------------------
module uart_pixel_packer
    import uart_tft_pkg::*;
#(
    parameter int          PIX_W       = 16,
    parameter int          BYTE_ORDER  = 0,
    parameter int          IMG_H       = DEF_IMG_H,
    parameter int          IMG_V       = DEF_IMG_V,
    parameter int          SYNC_EN     = 1,
    parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int          TIMEOUT_CYC = 500000
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [7:0]                       byte_data,
    input  logic                             byte_valid,
    output logic [PIX_W-1:0]                 pix_data,
    output logic                             pix_valid,
    output logic                             frame_load,
    output logic                             frame_done,
    output logic [clog2(IMG_H*IMG_V+1)-1:0]  pix_cnt,
    output logic                             err_timeout,
    output logic                             locked
);

    localparam int               BPP      = PIX_W / 8;
    localparam int               NPIX     = IMG_H * IMG_V;
    localparam int               CNT_W    = clog2(NPIX + 1);
    localparam int               BC_W     = (BPP > 1) ? clog2(BPP) : 1;
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BPP - 1);
    localparam logic [CNT_W-1:0] NPIX_C   = CNT_W'(NPIX);
    localparam pk_state_t        ST_RESET = (SYNC_EN != 0) ? HUNT : DATA;

    pk_state_t        state;
    logic [BC_W-1:0]  byte_idx;
    logic [PIX_W-1:0] asm_q;
    logic [PIX_W-1:0] asm_next;
    logic             start_pend;
    logic [CNT_W-1:0] cnt_base;
    logic [CNT_W-1:0] cnt_next;
    logic             in_data;
    logic             gap_expire;

    assign in_data = (state == DATA);

    gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (in_data),
        .clr    (byte_valid),
        .expire (gap_expire)
    );

    // Drop the current byte into its slot of the assembly word.
    always_comb begin
        asm_next = asm_q;
        if (BYTE_ORDER == 0) begin
            asm_next[8*byte_idx +: 8] = byte_data;
        end else begin
            asm_next[PIX_W-8-8*byte_idx +: 8] = byte_data;
        end
    end

    // A pending frame start clears the count in the same cycle a pixel may
    // complete, so the first pixel of the new frame counts as 1.
    assign cnt_base = start_pend ? '0 : pix_cnt;
    assign cnt_next = cnt_base + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RESET;
            byte_idx    <= '0;
            asm_q       <= '0;
            start_pend  <= (SYNC_EN == 0);
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            frame_load  <= 1'b0;
            frame_done  <= 1'b0;
            pix_cnt     <= '0;
            err_timeout <= 1'b0;
            locked      <= 1'b0;
        end else begin
            pix_valid   <= 1'b0;
            frame_load  <= 1'b0;
            frame_done  <= 1'b0;
            err_timeout <= 1'b0;

            // locked drops one cycle after the end-of-frame strobes; a
            // restart below re-asserts it in the same cycle.
            if (frame_done || err_timeout) begin
                locked <= 1'b0;
            end

            // Free-running framing: a new frame begins without a header.
            if (start_pend) begin
                start_pend <= 1'b0;
                frame_load <= 1'b1;
                locked     <= 1'b1;
                pix_cnt    <= '0;
            end

            unique case (state)
                HUNT: begin
                    if (byte_valid && (byte_data == SYNC_WORD[15:8])) begin
                        state <= HDR;
                    end
                end

                HDR: begin
                    if (byte_valid) begin
                        if (byte_data == SYNC_WORD[7:0]) begin
                            state      <= DATA;
                            byte_idx   <= '0;
                            asm_q      <= '0;
                            pix_cnt    <= '0;
                            frame_load <= 1'b1;
                            locked     <= 1'b1;
                        end else if (byte_data != SYNC_WORD[15:8]) begin
                            state <= HUNT;
                        end
                        // a repeated high byte keeps us in HDR
                    end
                end

                DATA: begin
                    if (gap_expire) begin
                        err_timeout <= 1'b1;
                        pix_cnt     <= '0;
                        byte_idx    <= '0;
                        asm_q       <= '0;
                        if (SYNC_EN != 0) begin
                            state <= HUNT;
                        end else begin
                            start_pend <= 1'b1;
                        end
                    end else if (byte_valid) begin
                        if (byte_idx == BC_LAST) begin
                            pix_data  <= asm_next;
                            pix_valid <= 1'b1;
                            pix_cnt   <= cnt_next;
                            byte_idx  <= '0;
                            asm_q     <= '0;
                            if (cnt_next == NPIX_C) begin
                                frame_done <= 1'b1;
                                if (SYNC_EN != 0) begin
                                    state <= HUNT;
                                end else begin
                                    start_pend <= 1'b1;
                                end
                            end
                        end else begin
                            asm_q    <= asm_next;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_pixel_packer.sv
// ----------------------------------------------------------------------------
// tb_uart_pixel_packer
// Three packers share one byte stream: A = 16-bit LSB-first with header,
// B = 24-bit MSB-first with header, C = 16-bit free-running. Each is tracked
// by a byte-level reference model and compared every cycle, with directed
// literal checks pinning the key scenarios.
// ----------------------------------------------------------------------------
module tb_uart_pixel_packer;

    localparam int          NPIX = 8;
    localparam int          TMO  = 100;
    localparam logic [7:0]  SYNC_HI = 8'hAA;
    localparam logic [7:0]  SYNC_LO = 8'h55;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bd = 8'h00;
    logic       bv = 1'b0;

    always #5 clk = ~clk;

    logic [15:0] pd_a, pd_c;
    logic [23:0] pd_b;
    logic [3:0]  pc_a, pc_b, pc_c;
    logic [2:0]  pv, fl, fd, to, lk;

    uart_pixel_packer #(.PIX_W(16), .BYTE_ORDER(0), .IMG_H(4), .IMG_V(2), .SYNC_EN(1),
                        .SYNC_WORD(16'hAA55), .TIMEOUT_CYC(TMO)) dut_a (
        .clk(clk), .rst_n(rst_n), .byte_data(bd), .byte_valid(bv),
        .pix_data(pd_a), .pix_valid(pv[0]), .frame_load(fl[0]), .frame_done(fd[0]),
        .pix_cnt(pc_a), .err_timeout(to[0]), .locked(lk[0]));

    uart_pixel_packer #(.PIX_W(24), .BYTE_ORDER(1), .IMG_H(4), .IMG_V(2), .SYNC_EN(1),
                        .SYNC_WORD(16'hAA55), .TIMEOUT_CYC(TMO)) dut_b (
        .clk(clk), .rst_n(rst_n), .byte_data(bd), .byte_valid(bv),
        .pix_data(pd_b), .pix_valid(pv[1]), .frame_load(fl[1]), .frame_done(fd[1]),
        .pix_cnt(pc_b), .err_timeout(to[1]), .locked(lk[1]));

    uart_pixel_packer #(.PIX_W(16), .BYTE_ORDER(0), .IMG_H(4), .IMG_V(2), .SYNC_EN(0),
                        .SYNC_WORD(16'hAA55), .TIMEOUT_CYC(TMO)) dut_c (
        .clk(clk), .rst_n(rst_n), .byte_data(bd), .byte_valid(bv),
        .pix_data(pd_c), .pix_valid(pv[2]), .frame_load(fl[2]), .frame_done(fd[2]),
        .pix_cnt(pc_c), .err_timeout(to[2]), .locked(lk[2]));

    // ---------------- reference model ----------------
    int pw [3] = '{16, 24, 16};
    int bo [3] = '{0, 1, 0};
    int se [3] = '{1, 1, 0};

    int          m_mode [3];      // 0 hunting, 1 header half seen, 2 in frame
    logic [7:0]  m_b    [3][4];   // bytes of the pixel being collected
    int          m_nb   [3];
    int          m_idle [3];      // idle cycles since last byte inside a frame
    bit          m_start[3];      // free-running frame start due next cycle

    logic [31:0] e_pix [3];
    bit          e_pv [3], e_fl [3], e_fd [3], e_to [3], e_lk [3];
    int          e_cnt [3];

    function automatic logic [31:0] compose(input int i);
        logic [31:0] p;
        int n;
        p = 32'h0;
        n = pw[i] / 8;
        for (int k = 0; k < n; k++) begin
            if (bo[i] == 0) p = p | (32'(m_b[i][k]) << (8 * k));
            else            p = p | (32'(m_b[i][k]) << (8 * (n - 1 - k)));
        end
        return p;
    endfunction

    task automatic model_reset(input int i);
        m_mode[i]  = (se[i] != 0) ? 0 : 2;
        m_nb[i]    = 0;
        m_idle[i]  = 0;
        m_start[i] = (se[i] == 0);
        e_pix[i] = 32'h0;
        e_pv[i] = 0; e_fl[i] = 0; e_fd[i] = 0; e_to[i] = 0; e_lk[i] = 0;
        e_cnt[i] = 0;
    endtask

    task automatic model_step(input int i);
        bit ended;
        int bpp;
        bpp   = pw[i] / 8;
        ended = e_fd[i] || e_to[i];
        e_pv[i] = 0; e_fl[i] = 0; e_fd[i] = 0; e_to[i] = 0;
        if (ended) e_lk[i] = 0;
        if (m_start[i]) begin
            m_start[i] = 0;
            e_fl[i] = 1; e_lk[i] = 1; e_cnt[i] = 0;
        end
        if (m_mode[i] == 2 && !bv) begin
            m_idle[i]++;
            if (m_idle[i] == TMO) begin
                e_to[i] = 1; e_cnt[i] = 0; m_nb[i] = 0; m_idle[i] = 0;
                if (se[i] != 0) m_mode[i] = 0;
                else            m_start[i] = 1;
            end
        end else begin
            m_idle[i] = 0;
        end
        if (bv) begin
            case (m_mode[i])
                0: if (bd == SYNC_HI) m_mode[i] = 1;
                1: begin
                    if (bd == SYNC_LO) begin
                        m_mode[i] = 2; m_nb[i] = 0;
                        e_fl[i] = 1; e_lk[i] = 1; e_cnt[i] = 0;
                    end else if (bd != SYNC_HI) begin
                        m_mode[i] = 0;
                    end
                end
                default: begin
                    m_b[i][m_nb[i]] = bd;
                    m_nb[i]++;
                    if (m_nb[i] == bpp) begin
                        m_nb[i] = 0;
                        e_pix[i] = compose(i);
                        e_pv[i] = 1;
                        e_cnt[i]++;
                        if (e_cnt[i] == NPIX) begin
                            e_fd[i] = 1;
                            if (se[i] != 0) m_mode[i] = 0;
                            else            m_start[i] = 1;
                        end
                    end
                end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) model_reset(i);
        end else begin
            for (int i = 0; i < 3; i++) model_step(i);
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] dpix(input int i);
        case (i)
            0:       return {16'h0, pd_a};
            1:       return {8'h0, pd_b};
            default: return {16'h0, pd_c};
        endcase
    endfunction

    function automatic logic [31:0] dcnt(input int i);
        case (i)
            0:       return {28'h0, pc_a};
            1:       return {28'h0, pc_b};
            default: return {28'h0, pc_c};
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model pix_data[%0d]", i),    dpix(i),        e_pix[i]);
                check($sformatf("model pix_valid[%0d]", i),   32'(pv[i]),     32'(e_pv[i]));
                check($sformatf("model frame_load[%0d]", i),  32'(fl[i]),     32'(e_fl[i]));
                check($sformatf("model frame_done[%0d]", i),  32'(fd[i]),     32'(e_fd[i]));
                check($sformatf("model pix_cnt[%0d]", i),     dcnt(i),        32'(e_cnt[i]));
                check($sformatf("model err_timeout[%0d]", i), 32'(to[i]),     32'(e_to[i]));
                check($sformatf("model locked[%0d]", i),      32'(lk[i]),     32'(e_lk[i]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bd = b;
        bv = 1'b1;
        tick();
        bv = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        idle(n);
        rst_n = 1'b1;
    endtask

    function automatic logic [7:0] pick_byte();
        int r;
        r = $urandom_range(0, 9);
        if (r < 3) return SYNC_HI;
        if (r < 6) return SYNC_LO;
        return 8'($urandom);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1);
    end

    initial begin
        int r;
        int n;
        idle(3);
        check("reset pix_data a", {16'h0, pd_a}, 32'h0);
        check("reset pix_data b", {8'h0, pd_b}, 32'h0);
        check("reset outputs a", {27'h0, pv[0], fl[0], fd[0], to[0], lk[0]}, 32'h0);
        check("reset outputs c", {27'h0, pv[2], fl[2], fd[2], to[2], lk[2]}, 32'h0);
        check("reset pix_cnt a", {28'h0, pc_a}, 32'h0);
        chk_on = 1;
        rst_n = 1'b1;
        tick();
        check("c frame_load first cycle", 32'(fl[2]), 32'h1);
        check("c locked first cycle", 32'(lk[2]), 32'h1);
        check("a still hunting", 32'(lk[0]), 32'h0);

        // header then one pixel
        send(8'hAA); send(8'h55);
        check("a frame_load after header", 32'(fl[0]), 32'h1);
        check("a locked with frame_load", 32'(lk[0]), 32'h1);
        send(8'h34); send(8'h12);
        check("a pix_valid 1234", 32'(pv[0]), 32'h1);
        check("a pix_data 1234", {16'h0, pd_a}, 32'h1234);
        check("a pix_cnt 1", {28'h0, pc_a}, 32'h1);
        send(8'h78);
        check("b msb-first 341278", {8'h0, pd_b}, 32'h341278);

        // silence after a partial pixel: timeout exactly TMO cycles later
        idle(TMO - 1);
        check("a no timeout at 99", 32'(to[0]), 32'h0);
        tick();
        check("a timeout at 100", 32'(to[0]), 32'h1);
        check("a pix_cnt cleared", {28'h0, pc_a}, 32'h0);
        tick();
        check("a locked low after timeout", 32'(lk[0]), 32'h0);

        // 24-bit MSB-first pixel, then a byte landing on the expiry cycle
        send(8'hAA); send(8'h55); send(8'h01); send(8'h02); send(8'h03);
        check("b pix_data 010203", {8'h0, pd_b}, 32'h010203);
        idle(TMO - 1);
        send(8'h04);
        check("a byte at expiry: no timeout", 32'(to[0]), 32'h0);
        check("a pix_data 0403", {16'h0, pd_a}, 32'h0403);
        check("a pix_cnt 2", {28'h0, pc_a}, 32'h2);

        // header robustness
        idle(TMO + 5);
        send(8'hAA); send(8'h00); send(8'h55);
        check("a AA 00 55 not locked", 32'(lk[0]), 32'h0);
        send(8'hAA); send(8'hAA); send(8'h55);
        check("a AA AA 55 frame_load", 32'(fl[0]), 32'h1);
        check("a AA AA 55 locked", 32'(lk[0]), 32'h1);

        // full frame of 8 pixels
        for (int k = 0; k < 2 * NPIX; k++) send(8'($urandom));
        check("a frame_done with last pixel", {30'h0, fd[0], pv[0]}, 32'h3);
        check("a pix_cnt at frame end", {28'h0, pc_a}, 32'h8);
        tick();
        check("a locked falls after done", 32'(lk[0]), 32'h0);
        send(8'h12); send(8'h34);
        check("a pix_cnt holds after done", {28'h0, pc_a}, 32'h8);

        // randomized traffic
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 15) begin
                send(SYNC_HI); send(SYNC_LO);
            end else if (r < 75) begin
                n = $urandom_range(1, 24);
                for (int k = 0; k < n; k++) begin
                    if ($urandom_range(0, 3) == 0) tick();
                    else send(pick_byte());
                end
            end else if (r < 92) begin
                idle($urandom_range(1, 20));
            end else if (r < 97) begin
                idle($urandom_range(TMO - 5, TMO + 5));
            end else begin
                do_reset($urandom_range(1, 3));
            end
        end

        // free-running: reset mid-pixel discards the partial byte
        do_reset(2);
        tick();
        check("c frame_load after reset", 32'(fl[2]), 32'h1);
        send(8'h01); send(8'h02); send(8'h03);
        check("c pix_data 0201", {16'h0, pd_c}, 32'h0201);
        do_reset(3);
        tick();
        check("c frame_load after mid-frame reset", 32'(fl[2]), 32'h1);
        check("c pix_cnt after reset", {28'h0, pc_c}, 32'h0);
        send(8'h11); send(8'h22);
        check("c pixel 0 valid", 32'(pv[2]), 32'h1);
        check("c pixel 0 data", {16'h0, pd_c}, 32'h2211);
        check("c pixel 0 count", {28'h0, pc_c}, 32'h1);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
